// File: rtl/motion_vector_encoder_pkg.sv
// Shared types for the motion-vector encoder: FSM states, token record and
// the motion_code VLC table.
package mv_pkg;

   localparam int MV_VLC_MAX_LEN = 11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CALC,
      S_H_MC,
      S_H_RES,
      S_V_MC,
      S_V_RES,
      S_DONE
   } mv_state_t;

   typedef struct packed {
      logic [MV_VLC_MAX_LEN-1:0] code;
      logic [3:0]                len;
   } mv_vlc_t;

   // One bitstream token as handed to the packer.
   typedef struct packed {
      logic [15:0] bits;
      logic [4:0]  len;
   } mv_tok_t;

   // motion_code magnitude + sign -> right-aligned VLC. Every non-zero code is
   // a fixed prefix followed by the sign bit; magnitudes above 16 saturate.
   function automatic mv_vlc_t mv_vlc_lookup(input logic [4:0] mag, input logic sign);
      mv_vlc_t    vlc;
      logic [9:0] prefix;
      logic [3:0] plen;
      prefix = '0;
      plen   = '0;
      case (mag)
         5'd0:    begin prefix = 10'b0;          plen = 4'd0;  end
         5'd1:    begin prefix = 10'b01;         plen = 4'd2;  end
         5'd2:    begin prefix = 10'b001;        plen = 4'd3;  end
         5'd3:    begin prefix = 10'b0001;       plen = 4'd4;  end
         5'd4:    begin prefix = 10'b000011;     plen = 4'd6;  end
         5'd5:    begin prefix = 10'b0000101;    plen = 4'd7;  end
         5'd6:    begin prefix = 10'b0000100;    plen = 4'd7;  end
         5'd7:    begin prefix = 10'b0000011;    plen = 4'd7;  end
         5'd8:    begin prefix = 10'b000001011;  plen = 4'd9;  end
         5'd9:    begin prefix = 10'b000001010;  plen = 4'd9;  end
         5'd10:   begin prefix = 10'b000001001;  plen = 4'd9;  end
         5'd11:   begin prefix = 10'b0000010001; plen = 4'd10; end
         5'd12:   begin prefix = 10'b0000010000; plen = 4'd10; end
         5'd13:   begin prefix = 10'b0000001111; plen = 4'd10; end
         5'd14:   begin prefix = 10'b0000001110; plen = 4'd10; end
         5'd15:   begin prefix = 10'b0000001101; plen = 4'd10; end
         default: begin prefix = 10'b0000001100; plen = 4'd10; end
      endcase
      if (mag == 5'd0) begin
         vlc.code = 11'd1;
         vlc.len  = 4'd1;
      end else begin
         vlc.code = {prefix, sign};
         vlc.len  = plen + 4'd1;
      end
      return vlc;
   endfunction

endpackage

// File: rtl/motion_vector_encoder_if.sv
// Request / token / result bundle of the motion-vector encoder.
// slave = encoder side, master = motion estimation + packer side.
interface motion_vector_encoder_if;
   logic               in_valid;
   logic               in_ready;
   logic signed [31:0] in_pred_h;
   logic signed [31:0] in_pred_v;
   logic signed [31:0] in_vec_h;
   logic signed [31:0] in_vec_v;
   logic               mvscale;
   logic               tok_valid;
   logic               tok_ready;
   logic [15:0]        tok_bits;
   logic [4:0]         tok_len;
   logic signed [31:0] out_pred_h;
   logic signed [31:0] out_pred_v;
   logic               done;
   logic               err;

   modport slave (
      input  in_valid, in_pred_h, in_pred_v, in_vec_h, in_vec_v, mvscale, tok_ready,
      output in_ready, tok_valid, tok_bits, tok_len, out_pred_h, out_pred_v, done, err
   );

   modport master (
      output in_valid, in_pred_h, in_pred_v, in_vec_h, in_vec_v, mvscale, tok_ready,
      input  in_ready, tok_valid, tok_bits, tok_len, out_pred_h, out_pred_v, done, err
   );
endinterface

// File: rtl/mv_component_encoder.sv
// One motion-vector component: wrapped differential -> motion_code VLC and
// fixed-length residual. Purely combinational.
module mv_component_encoder
   import mv_pkg::*;
#(
   parameter int R_SIZE = 1
) (
   input  logic signed [31:0]         pred,
   input  logic signed [31:0]         vec,
   output logic signed [5:0]          mcode,
   output logic [MV_VLC_MAX_LEN-1:0]  vlc_bits,
   output logic [3:0]                 vlc_len,
   output logic [7:0]                 res_bits,
   output logic [3:0]                 res_len,
   output logic                       has_residual
);
   localparam int                 F        = 1 << R_SIZE;
   localparam int                 DMV_MAX  = 16 * F - 1;
   localparam int                 DMV_MIN  = -16 * F;
   localparam logic signed [31:0] SPAN     = 32'(32 * F);
   localparam logic [31:0]        ROUND    = 32'(F - 1);
   localparam logic [7:0]         RES_MASK = 8'(F - 1);

   logic signed [31:0] diff;
   logic signed [31:0] dmv;
   logic               neg;
   logic [31:0]        abs_dmv;
   logic [31:0]        temp;
   logic [31:0]        mag;
   logic [4:0]         mag_sat;
   mv_vlc_t            vlc;

   // Wrap the differential into the f_code window, then split into code/residual.
   always_comb begin
      diff = vec - pred;
      if (diff > DMV_MAX) begin
         dmv = diff - SPAN;
      end else if (diff < DMV_MIN) begin
         dmv = diff + SPAN;
      end else begin
         dmv = diff;
      end
      neg     = dmv[31];
      abs_dmv = neg ? -dmv : dmv;
      temp    = abs_dmv + ROUND;
      mag     = temp >> R_SIZE;
      mag_sat = (mag > 32'd16) ? 5'd16 : mag[4:0];
      vlc     = mv_vlc_lookup(mag_sat, neg);
   end

   assign mcode        = neg ? -$signed({1'b0, mag_sat}) : $signed({1'b0, mag_sat});
   assign vlc_bits     = vlc.code;
   assign vlc_len      = vlc.len;
   assign res_bits     = temp[7:0] & RES_MASK;
   assign res_len      = 4'(R_SIZE);
   assign has_residual = (R_SIZE != 0);

endmodule

// File: rtl/motion_vector_encoder.sv
// Motion-vector encoder: accepts one (h,v) vector with its prediction and emits
// MSB-first VLC tokens (h code, h residual, v code, v residual) to the packer.
// Optional: MV_ENC_RANGE_CHECK_EN adds a sticky out-of-range flag on err.
module motion_vector_encoder
   import mv_pkg::*;
#(
   parameter int H_R_SIZE = 1,
   parameter int V_R_SIZE = 1
) (
   input logic                    clk,
   input logic                    rst,
   motion_vector_encoder_if.slave bus
);
   mv_state_t          state_reg, state_next;
   logic signed [31:0] pred_h_reg, vec_h_reg, pred_v_reg, vec_v_reg;
   logic               mvscale_reg;
   logic signed [31:0] out_pred_h_reg, out_pred_v_reg;
   logic signed [31:0] pred_c [2];
   logic signed [31:0] vec_c  [2];
   mv_tok_t            mc_tok [2];
   mv_tok_t            res_tok[2];
   logic [1:0]         res_en;

   // Field/frame scaling halves the vertical pair before differencing.
   assign pred_c[0] = pred_h_reg;
   assign vec_c[0]  = vec_h_reg;
   assign pred_c[1] = mvscale_reg ? (pred_v_reg >>> 1) : pred_v_reg;
   assign vec_c[1]  = mvscale_reg ? (vec_v_reg >>> 1) : vec_v_reg;

   // Component encoders (0 = horizontal, 1 = vertical) with their token registers.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_comp
         localparam int R = (gi == 0) ? H_R_SIZE : V_R_SIZE;
         logic signed [5:0]          mcode;
         logic [MV_VLC_MAX_LEN-1:0]  vlc_bits;
         logic [3:0]                 vlc_len, res_len;
         logic [7:0]                 res_bits;
         logic                       has_residual;
         mv_tok_t                    mc_tok_reg, res_tok_reg;
         logic                       res_en_reg;

         mv_component_encoder #(.R_SIZE(R)) u_enc (
            .pred         (pred_c[gi]),
            .vec          (vec_c[gi]),
            .mcode        (mcode),
            .vlc_bits     (vlc_bits),
            .vlc_len      (vlc_len),
            .res_bits     (res_bits),
            .res_len      (res_len),
            .has_residual (has_residual)
         );

         // Latch this component's tokens once, in S_CALC; a zero code carries no residual.
         always_ff @(posedge clk) begin
            if (rst) begin
               mc_tok_reg  <= '0;
               res_tok_reg <= '0;
               res_en_reg  <= 1'b0;
            end else if (state_reg == S_CALC) begin
               mc_tok_reg  <= '{bits: {5'd0, vlc_bits}, len: {1'b0, vlc_len}};
               res_tok_reg <= '{bits: {8'd0, res_bits}, len: {1'b0, res_len}};
               res_en_reg  <= has_residual && (mcode != 6'sd0);
            end
         end

         assign mc_tok[gi]  = mc_tok_reg;
         assign res_tok[gi] = res_tok_reg;
         assign res_en[gi]  = res_en_reg;
      end
   endgenerate

   // Capture the request at accept; update predictions in S_CALC.
   always_ff @(posedge clk) begin
      if (rst) begin
         pred_h_reg     <= '0;
         vec_h_reg      <= '0;
         pred_v_reg     <= '0;
         vec_v_reg      <= '0;
         mvscale_reg    <= 1'b0;
         out_pred_h_reg <= '0;
         out_pred_v_reg <= '0;
      end else begin
         if (state_reg == S_IDLE && bus.in_valid) begin
            pred_h_reg  <= bus.in_pred_h;
            vec_h_reg   <= bus.in_vec_h;
            pred_v_reg  <= bus.in_pred_v;
            vec_v_reg   <= bus.in_vec_v;
            mvscale_reg <= bus.mvscale;
         end
         if (state_reg == S_CALC) begin
            out_pred_h_reg <= vec_h_reg;
            out_pred_v_reg <= mvscale_reg ? (vec_c[1] <<< 1) : vec_v_reg;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next state and token output mux; one state advance per token handshake.
   always_comb begin
      state_next    = state_reg;
      bus.in_ready  = 1'b0;
      bus.tok_valid = 1'b0;
      bus.tok_bits  = '0;
      bus.tok_len   = '0;
      bus.done      = 1'b0;
      case (state_reg)
         S_IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_next = S_CALC;
         end
         S_CALC: state_next = S_H_MC;
         S_H_MC: begin
            bus.tok_valid = 1'b1;
            bus.tok_bits  = mc_tok[0].bits;
            bus.tok_len   = mc_tok[0].len;
            if (bus.tok_ready) state_next = res_en[0] ? S_H_RES : S_V_MC;
         end
         S_H_RES: begin
            bus.tok_valid = 1'b1;
            bus.tok_bits  = res_tok[0].bits;
            bus.tok_len   = res_tok[0].len;
            if (bus.tok_ready) state_next = S_V_MC;
         end
         S_V_MC: begin
            bus.tok_valid = 1'b1;
            bus.tok_bits  = mc_tok[1].bits;
            bus.tok_len   = mc_tok[1].len;
            if (bus.tok_ready) state_next = res_en[1] ? S_V_RES : S_DONE;
         end
         S_V_RES: begin
            bus.tok_valid = 1'b1;
            bus.tok_bits  = res_tok[1].bits;
            bus.tok_len   = res_tok[1].len;
            if (bus.tok_ready) state_next = S_DONE;
         end
         S_DONE: begin
            bus.done   = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   assign bus.out_pred_h = out_pred_h_reg;
   assign bus.out_pred_v = out_pred_v_reg;

`ifdef MV_ENC_RANGE_CHECK_EN
   logic [1:0] oor;
   logic       err_reg;

   for (gi = 0; gi < 2; gi++) begin : g_range
      localparam int RF = 1 << ((gi == 0) ? H_R_SIZE : V_R_SIZE);
      assign oor[gi] = (vec_c[gi] > 16 * RF - 1) || (vec_c[gi] < -16 * RF);
   end

   // Sticky flag for a (scaled) vector outside the codable window.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_reg <= 1'b0;
      end else if (state_reg == S_CALC && oor != 2'b00) begin
         err_reg <= 1'b1;
      end
   end

   assign bus.err = err_reg;
`else
   assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_motion_vector_encoder.sv
// Bench for motion_vector_encoder: directed corner vectors plus random vectors
// against a string-table reference model of the motion_code VLC.
module tb_motion_vector_encoder;
   localparam int H_R = 2;
   localparam int V_R = 0;
`ifdef MV_ENC_RANGE_CHECK_EN
   localparam bit RANGE_EN = 1'b1;
`else
   localparam bit RANGE_EN = 1'b0;
`endif

   typedef struct {
      int bits;
      int len;
   } tok_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   int   err_exp = 0;
   tok_t exp_q[$];

   string vlc_tab [0:16] = '{"1", "01", "001", "0001", "000011", "0000101", "0000100",
                             "0000011", "000001011", "000001010", "000001001", "0000010001",
                             "0000010000", "0000001111", "0000001110", "0000001101", "0000001100"};

   motion_vector_encoder_if bus();

   motion_vector_encoder #(.H_R_SIZE(H_R), .V_R_SIZE(V_R)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: wrap by modulo into [-16f,16f), code = ceil(|d|/f), bits from the VLC strings.
   function automatic void model_comp(input int r, input int pred, input int vec);
      int    f, span, t, d, absd, m;
      string s;
      tok_t  tk;
      f    = 1 << r;
      span = 32 * f;
      t    = (vec - pred + 16 * f) % span;
      if (t < 0) t += span;
      d    = t - 16 * f;
      absd = (d < 0) ? -d : d;
      m    = (absd + f - 1) / f;
      s    = vlc_tab[m];
      if (m != 0) begin
         if (d < 0) s = {s, "1"};
         else       s = {s, "0"};
      end
      tk.bits = 0;
      tk.len  = s.len();
      for (int i = 0; i < s.len(); i++) tk.bits = tk.bits * 2 + ((s[i] == "1") ? 1 : 0);
      exp_q.push_back(tk);
      if (r != 0 && d != 0) begin
         tk.bits = (absd + f - 1) % f;
         tk.len  = r;
         exp_q.push_back(tk);
      end
   endfunction

   function automatic bit out_of_range(input int r, input int v);
      int f;
      f = 1 << r;
      return (v > 16 * f - 1) || (v < -16 * f);
   endfunction

   function automatic int rnd(input int f, input int k);
      return int'($urandom_range(0, 2 * k * f - 1)) - k * f;
   endfunction

   task automatic run_vec(input int ph, input int pv, input int vh, input int vv,
                          input bit ms, input int stall);
      int ncyc, got, done_seen, first_valid, hold_left, seen_bits, seen_len, sp, sv;
      bit fresh, fin;
      exp_q = {};
      sp = ms ? (pv >>> 1) : pv;
      sv = ms ? (vv >>> 1) : vv;
      model_comp(H_R, ph, vh);
      model_comp(V_R, sp, sv);
      if (RANGE_EN && (out_of_range(H_R, vh) || out_of_range(V_R, sv))) err_exp = 1;

      @(negedge clk);
      check("in_ready_idle", bus.in_ready, 1);
      bus.in_valid  = 1'b1;
      bus.in_pred_h = ph;
      bus.in_pred_v = pv;
      bus.in_vec_h  = vh;
      bus.in_vec_v  = vv;
      bus.mvscale   = ms;
      bus.tok_ready = 1'b0;
      ncyc = 0; got = 0; done_seen = 0; first_valid = -1; hold_left = stall;
      fresh = 1'b1; fin = 1'b0; seen_bits = 0; seen_len = 0;
      while (!fin && ncyc < 400) begin
         @(negedge clk);
         ncyc++;
         if (ncyc == 1) begin
            // Inputs changing after accept must not matter.
            bus.in_valid  = 1'b0;
            bus.in_pred_h = $urandom;
            bus.in_pred_v = $urandom;
            bus.in_vec_h  = $urandom;
            bus.in_vec_v  = $urandom;
            bus.mvscale   = $urandom_range(0, 1);
         end
         if (bus.done) begin
            done_seen++;
            fin = 1'b1;
            bus.tok_ready = 1'b0;
         end else if (bus.tok_valid) begin
            if (first_valid < 0) first_valid = ncyc;
            if (fresh) begin
               seen_bits = bus.tok_bits;
               seen_len  = bus.tok_len;
               fresh     = 1'b0;
            end else begin
               check("hold_bits", bus.tok_bits, seen_bits);
               check("hold_len", bus.tok_len, seen_len);
            end
            if (hold_left > 0) begin
               hold_left--;
               bus.tok_ready = 1'b0;
            end else begin
               bus.tok_ready = 1'b1;
               if (got < exp_q.size()) begin
                  check("tok_bits", bus.tok_bits, exp_q[got].bits);
                  check("tok_len", bus.tok_len, exp_q[got].len);
               end else begin
                  check("extra_token", 1, 0);
               end
               got++;
               hold_left = stall;
               fresh     = 1'b1;
            end
         end else begin
            bus.tok_ready = 1'b0;
         end
      end
      if (!fin) check("done_timeout", 0, 1);
      check("first_tok_latency", first_valid, 2);
      check("tok_count", got, exp_q.size());
      check("done_count", done_seen, 1);
      check("out_pred_h", bus.out_pred_h, vh);
      check("out_pred_v", bus.out_pred_v, ms ? (vv >>> 1) * 2 : vv);
      check("err", bus.err, err_exp);
      @(negedge clk);
      check("done_one_cycle", bus.done, 0);
      check("in_ready_after", bus.in_ready, 1);
      $display("vec pred=(%0d,%0d) vec=(%0d,%0d) ms=%0d stall=%0d tokens=%0d/%0d",
               ph, pv, vh, vv, ms, stall, got, exp_q.size());
   endtask

   task automatic reset_mid_token();
      @(negedge clk);
      check("rst_in_ready", bus.in_ready, 1);
      bus.in_valid  = 1'b1;
      bus.in_pred_h = 0;
      bus.in_pred_v = 0;
      bus.in_vec_h  = 5;
      bus.in_vec_v  = 3;
      bus.mvscale   = 1'b0;
      bus.tok_ready = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("rst_h_mc_valid", bus.tok_valid, 1);
      @(negedge clk);
      check("rst_h_res_len", bus.tok_len, H_R);
      rst = 1'b1;
      @(negedge clk);
      check("rst_tok_valid", bus.tok_valid, 0);
      check("rst_in_ready_high", bus.in_ready, 1);
      check("rst_done", bus.done, 0);
      check("rst_err", bus.err, 0);
      check("rst_out_pred_h", bus.out_pred_h, 0);
      rst = 1'b0;
      bus.tok_ready = 1'b0;
      err_exp = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rst_no_done", bus.done, 0);
         check("rst_no_tok", bus.tok_valid, 0);
      end
      $display("vec reset in S_H_RES, partial vector discarded");
   endtask

   initial begin
      int fh, fv, ph, pv, vh, vv;
      bit ms;
      bus.in_valid  = 1'b0;
      bus.in_pred_h = 0;
      bus.in_pred_v = 0;
      bus.in_vec_h  = 0;
      bus.in_vec_v  = 0;
      bus.mvscale   = 1'b0;
      bus.tok_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("reset_in_ready", bus.in_ready, 1);
      check("reset_tok_valid", bus.tok_valid, 0);
      check("reset_tok_bits", bus.tok_bits, 0);
      check("reset_tok_len", bus.tok_len, 0);
      check("reset_done", bus.done, 0);
      check("reset_err", bus.err, 0);
      check("reset_out_pred_h", bus.out_pred_h, 0);
      check("reset_out_pred_v", bus.out_pred_v, 0);

      run_vec(0, 0, 3, 0, 1'b0, 0);      // small positive h, zero v
      run_vec(0, 0, -5, 1, 1'b0, 0);     // negative h code with residual
      run_vec(40, 0, -40, -1, 1'b0, 0);  // h differential wraps
      run_vec(0, 8, 0, 14, 1'b1, 0);     // mvscale on vertical
      run_vec(0, 0, 63, 15, 1'b0, 0);    // top of window, longest codes
      run_vec(0, 0, -64, -16, 1'b0, 0);  // bottom of window
      run_vec(-64, 15, 63, -16, 1'b0, 0);// opposite corners wrap
      run_vec(3, -7, -9, 6, 1'b0, 5);    // ready held low 5 cycles per token
      run_vec(0, 0, 80, 20, 1'b0, 1);    // vectors outside the window
      run_vec(0, 0, 2, 1, 1'b0, 0);      // err stays sticky

      fh = 1 << H_R;
      fv = 1 << V_R;
      for (int i = 0; i < 40; i++) begin
         ms = $urandom_range(0, 1);
         ph = rnd(fh, 16);
         vh = ($urandom_range(0, 7) == 0) ? rnd(fh, 24) : rnd(fh, 16);
         pv = rnd(fv, ms ? 32 : 16);
         vv = ($urandom_range(0, 7) == 0) ? rnd(fv, ms ? 48 : 24) : rnd(fv, ms ? 32 : 16);
         run_vec(ph, pv, vh, vv, ms, $urandom_range(0, 2));
      end

      reset_mid_token();
      run_vec(1, 2, 3, 4, 1'b1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
